// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ valid/ready requesters.
// Grants are held for at most MAX_BURST accepted words; fifo_full stalls the grant without releasing it.
module fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_push,
  output logic [WIDTH-1:0]         fifo_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;

  logic [IDW-1:0] next_g;
  logic [IDW-1:0] base;
  logic [IDW-1:0] sel;
  logic           found;
  logic           gv;
  logic           rel;

  always_comb begin
    if (grant_id == IDW'(NUM_REQ - 1)) next_g = '0;
    else                               next_g = grant_id + 1'b1;
  end

  // On release the scan starts just past the current holder, so selection can reuse one scanner.
  assign base = (state == GRANT) ? next_g : ptr;

  always_comb begin
    int j;
    logic [IDW-1:0] cand;
    found = 1'b0;
    sel   = '0;
    j     = 0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(base) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDW'(j);
      if (req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign gv        = req_valid[grant_id];
  assign fifo_data = req_data[grant_id*WIDTH +: WIDTH];
  assign fifo_push = rst_n && (state == GRANT) && gv && !fifo_full;

  always_comb begin
    req_ready = '0;
    if (rst_n && (state == GRANT) && !fifo_full) req_ready[grant_id] = 1'b1;
  end

  assign rel = (state == GRANT) && (!gv || (fifo_push && (cnt == CNT_LAST)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            grant_id <= sel;
            grant    <= ONE << sel;
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr <= next_g;
            if (found) begin
              grant_id <= sel;
              grant    <= ONE << sel;
              cnt      <= '0;
            end else begin
              state <= IDLE;
              grant <= '0;
              busy  <= 1'b0;
            end
          end else if (fifo_push) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based arbiter model.
module tb_fifo_push_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          fifo_full;
  logic          fifo_push;
  logic [W-1:0]  fifo_data;
  logic [NR-1:0] grant;
  logic [1:0]    grant_id;
  logic          busy;

  fifo_push_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_push(fifo_push),
    .fifo_data(fifo_data), .grant(grant), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] lq[NR][$];
  bit   lv[NR];
  int   p_valid = 100, p_pop = 100;
  bit   force_full = 0, rst_drv = 0;
  int   fq = 0, cyc = 0;

  bit m_known = 0, m_busy = 0, m_gid_rst = 0;
  int m_g = 0, m_ptr = 0, m_cnt = 0, cur_burst = 0;

  int grant_log[$], burst_log[$], push_cycle[$], word_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_list(input string name, input int q[$], input int e[$]);
    chk({name, "_len"}, q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk(name, (i < q.size()) ? q[i] : -1, e[i]);
  endtask

  function automatic int pick(input int b, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (b + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit lanes_active();
    for (int i = 0; i < NR; i++) if (lv[i] || lq[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic step();
    logic [NR-1:0] v, e_ready;
    bit e_push, full, rel, pop;
    int s;
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      if (!lv[i] && lq[i].size() > 0 && $urandom_range(99) < p_valid) lv[i] = 1;
    for (int i = 0; i < NR; i++) begin
      v[i] = lv[i];
      req_data[i*W +: W] = lv[i] ? lq[i][0] : 8'h00;
    end
    req_valid = v;
    full = (fq >= 16) || force_full;
    fifo_full = full;
    rst_n = rst_drv;
    #1;
    e_push = 0;
    e_ready = '0;
    if (rst_drv && m_busy) begin
      if (!full) e_ready[m_g] = 1'b1;
      e_push = v[m_g] && !full;
    end
    chk("fifo_push", fifo_push, e_push);
    chk("req_ready", req_ready, e_ready);
    if (m_known) begin
      chk("busy", busy, m_busy);
      chk("grant", grant, m_busy ? (4'b0001 << m_g) : 4'b0000);
      if (m_busy || m_gid_rst) chk("grant_id", grant_id, m_busy ? m_g : 0);
    end
    if (e_push) chk("fifo_data", fifo_data, lq[m_g][0]);

    if (!rst_drv) begin
      m_known = 1; m_busy = 0; m_ptr = 0; m_cnt = 0; m_gid_rst = 1; cur_burst = 0;
    end else if (!m_busy) begin
      s = pick(m_ptr, v);
      if (s >= 0) begin
        m_busy = 1; m_g = s; m_cnt = 0; cur_burst = 0; m_gid_rst = 0;
        grant_log.push_back(s);
      end
    end else begin
      if (e_push) begin
        word_log.push_back(int'(lq[m_g][0]));
        push_cycle.push_back(cyc);
        cur_burst++;
      end
      rel = !v[m_g] || (e_push && m_cnt == MB - 1);
      if (rel) begin
        burst_log.push_back(cur_burst);
        m_ptr = (m_g + 1) % NR;
        s = pick(m_ptr, v);
        if (s >= 0) begin
          m_g = s; m_cnt = 0; cur_burst = 0;
          grant_log.push_back(s);
        end else m_busy = 0;
      end else if (e_push) m_cnt++;
    end

    pop = (fq > 0) && ($urandom_range(99) < p_pop);
    fq = fq + (e_push ? 1 : 0) - (pop ? 1 : 0);
    for (int i = 0; i < NR; i++)
      if (e_ready[i] && v[i]) begin
        void'(lq[i].pop_front());
        lv[i] = 0;
      end
    cyc++;
  endtask

  task automatic clear_logs();
    grant_log.delete(); burst_log.delete(); push_cycle.delete(); word_log.delete();
  endtask

  task automatic reset_all();
    for (int i = 0; i < NR; i++) begin lq[i].delete(); lv[i] = 0; end
    force_full = 0; fq = 0; p_valid = 100; p_pop = 100;
    rst_drv = 0; step(); step();
    rst_drv = 1;
    clear_logs();
  endtask

  task automatic run_until_done(input int max);
    int n;
    n = 0;
    while ((m_busy || lanes_active()) && n < max) begin step(); n++; end
    chk("drain_done", (n < max), 1);
    step();
  endtask

  task automatic fill(input int lane, input int nwords);
    for (int k = 0; k < nwords; k++) lq[lane].push_back(8'(16 * lane + k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    req_valid = '0; req_data = '0; fifo_full = 0; rst_n = 0;

    // reset with every requester valid
    for (int i = 0; i < NR; i++) fill(i, 1);
    rst_drv = 0;
    step(); step();
    chk("rst_grant", grant, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_push", fifo_push, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid_drv", req_valid, 4'hF);

    // single requester
    reset_all();
    lq[2].push_back(8'h20); lq[2].push_back(8'h21); lq[2].push_back(8'h22);
    step(); step();
    chk("single_grant", grant, 4'b0100);
    run_until_done(50);
    chk("single_busy_after", busy, 0);
    chk("single_ptr", m_ptr, 3);
    chk_list("single_words", word_log, '{32'h20, 32'h21, 32'h22});
    chk_list("single_grants", grant_log, '{2});
    chk("single_consecutive", push_cycle[2] - push_cycle[0], 2);

    // fair rotation
    reset_all();
    for (int i = 0; i < NR; i++) fill(i, 6);
    run_until_done(200);
    chk_list("rot_grants", grant_log, '{0, 1, 2, 3, 0, 1, 2, 3});
    chk_list("rot_bursts", burst_log, '{4, 4, 4, 4, 2, 2, 2, 2});
    chk("rot_words", word_log.size(), 24);
    chk("rot_span", push_cycle[23] - push_cycle[0] + 1, 27);
    for (int i = 0; i < NR; i++) begin
      int k;
      k = 0;
      foreach (word_log[j]) if ((word_log[j] >> 4) == i) begin
        chk("rot_lane_order", word_log[j], 16 * i + k);
        k++;
      end
    end

    // backpressure
    reset_all();
    fill(1, 6);
    n = 0;
    while (word_log.size() < 2 && n < 20) begin step(); n++; end
    chk("bp_reach", (n < 20), 1);
    force_full = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_push", fifo_push, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_gid", grant_id, 1);
    end
    force_full = 0;
    run_until_done(50);
    chk_list("bp_bursts", burst_log, '{4, 2});
    chk_list("bp_grants", grant_log, '{1, 1});
    chk("bp_resume_gap", push_cycle[2] - push_cycle[1], 4);

    // sole requester
    reset_all();
    fill(3, 10);
    run_until_done(60);
    chk("sole_words", word_log.size(), 10);
    chk("sole_span", push_cycle[9] - push_cycle[0], 9);
    chk_list("sole_grants", grant_log, '{3, 3, 3});
    chk_list("sole_bursts", burst_log, '{4, 4, 2});

    // reset in the middle of requester 0's burst
    reset_all();
    for (int i = 0; i < NR; i++) fill(i, 6);
    n = 0;
    while (word_log.size() < 2 && n < 20) begin step(); n++; end
    rst_drv = 0;
    step();
    chk("mid_rst_push", fifo_push, 0);
    rst_drv = 1;
    clear_logs();
    run_until_done(300);
    chk("mid_first_grant", grant_log[0], 0);
    chk("mid_first_burst", burst_log[0], 4);
    chk("mid_words", word_log.size(), 22);

    // randomized traffic with backpressure and occasional resets
    reset_all();
    for (int it = 0; it < 3000; it++) begin
      if (it % 500 == 0) begin
        p_valid = $urandom_range(30, 100);
        p_pop   = $urandom_range(10, 100);
      end
      for (int i = 0; i < NR; i++)
        if (lq[i].size() == 0 && $urandom_range(9) == 0) begin
          int cnt_w;
          cnt_w = $urandom_range(1, 8);
          for (int k = 0; k < cnt_w; k++) lq[i].push_back(8'($urandom));
        end
      force_full = ($urandom_range(19) == 0);
      rst_drv = ($urandom_range(499) != 0);
      step();
    end
    rst_drv = 1; force_full = 0; p_pop = 100; p_valid = 100;
    run_until_done(500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter that shares the single write port of a `sync_fifo` among `NUM_REQ` requesters. Each requester offers words on a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst and drives the FIFO's `push`/`data_in` from the granted lane. It sits directly in front of the FIFO, with the FIFO's `full` fed back as backpressure.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 8: data word width; must match the FIFO `WIDTH`.
- `MAX_BURST`, 4: maximum accepted words per grant, ≥1.
- `IDW`: derived, `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  NUM_REQ  bit i: requester i has a word.
- `req_data`  in  NUM_REQ*WIDTH  requester i's word at `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NUM_REQ  bit i: word from requester i accepted this cycle when valid.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_push`  out  1  connects to FIFO `push`.
- `fifo_data`  out  WIDTH  connects to FIFO `data_in`.
- `grant`  out  NUM_REQ  registered one-hot grant; all-zero when idle.
- `grant_id`  out  IDW  registered index of the granted requester.
- `busy`  out  1  registered; high while any grant is held.

## Operation
- **State:**
  - FSM states IDLE and GRANT.
  - Round-robin pointer `ptr` (IDW bits): the highest-priority index.
  - Burst counter `cnt`, wide enough for 0..MAX_BURST-1.
- **Selection:** the first i with `req_valid[i]=1`, scanning `ptr, ptr+1, …` modulo NUM_REQ.
- **IDLE:**
  - No valid requester: stay in IDLE.
  - Otherwise, on the next edge: go to GRANT with the selected index, `cnt←0`, `busy←1`.
- **GRANT (index g):**
  - `req_ready[g] = !fifo_full`; all other ready bits are 0.
  - `fifo_push = req_valid[g] & !fifo_full`.
  - `fifo_data = req_data[g]` (combinational mux). `fifo_data` is don't-care when not pushing; the implementation drives lane `grant_id`.
  - Each push increments `cnt`.
- **Release** (at the edge ending the cycle) when either holds:
  - (a) a push occurs with `cnt==MAX_BURST-1`;
  - (b) `req_valid[g]==0`, in which case no push occurs that cycle.
- **On release:**
  - `ptr←g+1` (mod NUM_REQ).
  - Re-run selection in the same cycle using the current `req_valid` and the new ptr.
  - If a requester is found: go directly to GRANT for it with `cnt←0`, no bubble. Requester g may be regranted only if it is the sole valid requester.
  - Otherwise: go to IDLE, `grant←0`, `busy←0`.
- **Backpressure:** while `fifo_full=1` the grant is held and `cnt` is unchanged. Full never causes release; there is no stall timeout.
- **Ignored inputs:** requests from non-granted lanes are ignored and never acknowledged.
- **Requester rule:** a requester must hold `req_data` stable while `req_valid` is high and `req_ready` is low.

## Timing
- **Reset:** while `rst_n=0` at an edge:
  - `grant←0`, `grant_id←0`, `busy←0`, `ptr←0`, `cnt←0`, FSM←IDLE.
  - `fifo_push` and `req_ready` are forced to 0 combinationally while `rst_n=0`.
- **Reset mid-burst:** the grant drops at that edge. No partial state survives; arbitration restarts from requester 0.
- **Grant latency:**
  - `req_valid` rising in IDLE at cycle 0 gives `grant`/`busy` at cycle 1.
  - The first push is at cycle 1 if not full.
- **Throughput:** one word per cycle within a grant. Back-to-back grants add no idle cycle.
- **Bubble cost:** release via (b) costs exactly one non-push cycle.
- **Minimum burst:** `MAX_BURST=1` releases after every push, giving strict per-word round robin.

## Test plan
Configuration for all scenarios: NUM_REQ=4, WIDTH=8, MAX_BURST=4, driving a `sync_fifo` with DEPTH=16; the drainer pops whenever not empty unless stated.

- **Reset values:** hold `rst_n=0` for 2 cycles with all `req_valid=4'hF` → `grant=0`, `grant_id=0`, `busy=0`, `fifo_push=0`, `req_ready=0` throughout.
- **Single requester:** requester 2 offers 0x20,0x21,0x22, then drops valid → `grant=4'b0100` one cycle after valid; three consecutive pushes in order; FIFO pops 0x20,0x21,0x22; next cycle `busy=0`, `ptr=3`.
- **Fair rotation:** all four requesters continuously valid with 6 words each (data = 0x10*i+k) → grant order 0,1,2,3,0,1,2,3; bursts of 4,4,4,4 then 2,2,2,2; `fifo_push` high every cycle except the release-via-(b) cycles; per-requester order preserved.
- **Backpressure:** during a grant to requester 1 after 2 pushes, force `fifo_full=1` for 3 cycles → `fifo_push=0`, `req_ready=0`, `grant_id=1` held, `cnt` stays 2; after full clears, exactly 2 more pushes, then release.
- **Sole requester:** only requester 3 valid with 10 words → grants at pushes 0,4,8 stay on 3 with no bubble; all 10 words pushed in 10 consecutive cycles.
- **Reset mid-burst:** assert `rst_n=0` after requester 0's second push with all requesters valid → grant clears; after release the first grant goes to requester 0 with `cnt=0`.
